// File: rtl/dp_ram_sync_read.sv
// -----------------------------------------------------------------------------
// dp_ram_sync_read
//
// True dual-port RAM. Ports A and B share one clock and one storage array.
// Each port can read and write on every rising edge, and each port has a
// registered read output.
//
// Behaviour:
//   - Reads are read-first: a port that writes its own address on an edge
//     returns the word that was stored before that edge.
//   - When one port writes an address and the other port reads it on the same
//     edge, the reader sees the old word.
//   - When both ports write the same address on the same edge, port A wins.
//   - rst clears both read registers at once and holds them at zero. It also
//     blocks all writes while it is high. It never touches the array itself.
//
// Parameters:
//   DATA_WIDTH : word width in bits
//   ADDR_WIDTH : address width; depth = 2**ADDR_WIDTH words
//
// Ports:
//   clk          : clock; all accesses happen on the rising edge
//   rst          : asynchronous, active-high reset of the read registers
//   we_a/we_b    : write enable, per port
//   addr_a/addr_b: word address, per port
//   din_a/din_b  : write data, per port
//   dout_a/dout_b: registered read data, per port
// -----------------------------------------------------------------------------
module dp_ram_sync_read #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage array. It has no reset, so its power-up contents are undefined.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [DATA_WIDTH-1:0] r_dout_a;
  logic [DATA_WIDTH-1:0] r_dout_b;

  logic w_same_addr;
  logic w_collide;
  logic w_wr_a;
  logic w_wr_b;

  // Write qualification. In a same-address double write, port B is dropped,
  // so only port A's data reaches the array.
  always_comb begin
    w_same_addr = 1'b0;
    w_collide   = 1'b0;
    w_wr_a      = 1'b0;
    w_wr_b      = 1'b0;
    if (addr_a == addr_b) begin
      w_same_addr = 1'b1;
    end else begin
      w_same_addr = 1'b0;
    end
    w_collide = we_a & we_b & w_same_addr;
    if (rst) begin
      w_wr_a = 1'b0;
      w_wr_b = 1'b0;
    end else begin
      w_wr_a = we_a;
      w_wr_b = we_b & ~w_collide;
    end
  end

  // Array write from both ports. The contents are never reset.
  always_ff @(posedge clk) begin
    if (w_wr_a) begin
      r_mem[addr_a] <= din_a;
    end
    if (w_wr_b) begin
      r_mem[addr_b] <= din_b;
    end
  end

  // Port A read register. The read samples the array before this edge's
  // writes land, which gives read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_a <= {DATA_WIDTH{1'b0}};
    end else begin
      r_dout_a <= r_mem[addr_a];
    end
  end

  // Port B read register. It follows the same read-first rule as port A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_b <= {DATA_WIDTH{1'b0}};
    end else begin
      r_dout_b <= r_mem[addr_b];
    end
  end

  assign dout_a = r_dout_a;
  assign dout_b = r_dout_b;

endmodule

// File: tb/tb_dp_ram_sync_read.sv
module tb_dp_ram_sync_read;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we_a = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [DW-1:0] din_a = '0;
  logic [DW-1:0] dout_a;
  logic          we_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [DW-1:0] din_b = '0;
  logic [DW-1:0] dout_b;

  int n_checks = 0;
  int n_fail   = 0;

  dp_ram_sync_read #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .we_a  (we_a),
    .addr_a(addr_a),
    .din_a (din_a),
    .dout_a(dout_a),
    .we_b  (we_b),
    .addr_b(addr_b),
    .din_b (din_b),
    .dout_b(dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: an array of words plus a "known" flag per word.
  logic [DW-1:0] mm [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] exp_a = '0;
  logic [DW-1:0] exp_b = '0;
  bit            ka = 1'b0;
  bit            kb = 1'b0;

  // On each edge the model reads the old words first, then applies the
  // writes. Port A is applied last, so it wins a same-address collision.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_a = '0; exp_b = '0; ka = 1'b1; kb = 1'b1;
    end else begin
      exp_a = mm[addr_a]; ka = known[addr_a];
      exp_b = mm[addr_b]; kb = known[addr_b];
      if (we_b) begin mm[addr_b] = din_b; known[addr_b] = 1'b1; end
      if (we_a) begin mm[addr_a] = din_a; known[addr_a] = 1'b1; end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every meaningful output on the falling edge.
  always @(negedge clk) begin
    if (ka) check("model_dout_a", dout_a, exp_a);
    if (kb) check("model_dout_b", dout_b, exp_b);
  end

  // Drive one cycle of inputs, then return at the next falling edge, when
  // the outputs of the intervening rising edge are settled.
  task automatic cyc(input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    we_a = wa; addr_a = aa; din_a = da;
    we_b = wb; addr_b = ab; din_b = db;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_dout_a", dout_a, 8'h00);
    check("reset_dout_b", dout_b, 8'h00);
    rst = 1'b0;

    // Simultaneous distinct writes, then read them back.
    cyc(1'b1, 6'h01, 8'hAA, 1'b1, 6'h02, 8'hBB);
    cyc(1'b0, 6'h01, 8'h00, 1'b0, 6'h02, 8'h00);
    check("pair1_a", dout_a, 8'hAA);
    check("pair1_b", dout_b, 8'hBB);

    // Second pair, written over two edges.
    cyc(1'b1, 6'h03, 8'h11, 1'b0, 6'h02, 8'h00);
    cyc(1'b0, 6'h03, 8'h00, 1'b1, 6'h04, 8'h22);
    cyc(1'b0, 6'h03, 8'h00, 1'b0, 6'h04, 8'h00);
    check("pair2_a", dout_a, 8'h11);
    check("pair2_b", dout_b, 8'h22);

    // Read-first on the same port.
    cyc(1'b1, 6'h05, 8'h33, 1'b0, 6'h04, 8'h00);
    cyc(1'b1, 6'h05, 8'h44, 1'b0, 6'h04, 8'h00);
    check("rfirst_same_old", dout_a, 8'h33);
    cyc(1'b0, 6'h05, 8'h00, 1'b0, 6'h04, 8'h00);
    check("rfirst_same_new", dout_a, 8'h44);

    // Cross-port: B reads while A writes the same address.
    cyc(1'b1, 6'h05, 8'h55, 1'b0, 6'h05, 8'h00);
    check("rfirst_cross_old", dout_b, 8'h44);
    cyc(1'b0, 6'h05, 8'h00, 1'b0, 6'h05, 8'h00);
    check("rfirst_cross_new_a", dout_a, 8'h55);
    check("rfirst_cross_new_b", dout_b, 8'h55);

    // Write-write collision: port A wins.
    cyc(1'b0, 6'h06, 8'h00, 1'b1, 6'h06, 8'h01);
    cyc(1'b1, 6'h06, 8'h66, 1'b1, 6'h06, 8'h77);
    check("collide_old_a", dout_a, 8'h01);
    check("collide_old_b", dout_b, 8'h01);
    cyc(1'b0, 6'h06, 8'h00, 1'b0, 6'h06, 8'h00);
    check("collide_a", dout_a, 8'h66);
    check("collide_b", dout_b, 8'h66);

    // Address extremes.
    cyc(1'b1, 6'h00, 8'hC3, 1'b1, 6'h3F, 8'h5A);
    cyc(1'b0, 6'h3F, 8'h00, 1'b0, 6'h00, 8'h00);
    check("extreme_a_3f", dout_a, 8'h5A);
    check("extreme_b_00", dout_b, 8'hC3);

    // Asynchronous reset with nonzero outputs, and a write attempted during it.
    we_a = 1'b1; addr_a = 6'h01; din_a = 8'hEE;
    we_b = 1'b1; addr_b = 6'h02; din_b = 8'hDD;
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", dout_a, 8'h00);
    check("async_rst_b", dout_b, 8'h00);
    @(negedge clk);
    check("rst_hold_a", dout_a, 8'h00);
    check("rst_hold_b", dout_b, 8'h00);
    rst = 1'b0;
    cyc(1'b0, 6'h01, 8'h00, 1'b0, 6'h02, 8'h00);
    check("retain_a", dout_a, 8'hAA);
    check("retain_b", dout_b, 8'hBB);

    // Sweep: fill a range with a pattern, then read it back crosswise.
    for (int i = 8; i < 24; i++) begin
      cyc(1'b1, AW'(i), DW'(i) ^ 8'h5A, 1'b1, AW'(i + 16), DW'(i) ^ 8'hA5);
    end
    for (int i = 8; i < 24; i++) begin
      cyc(1'b0, AW'(i + 16), 8'h00, 1'b0, AW'(i), 8'h00);
    end
    check("sweep_last_a", dout_a, 8'h17 ^ 8'hA5);
    check("sweep_last_b", dout_b, 8'h17 ^ 8'h5A);

    cyc(1'b0, 6'h00, 8'h00, 1'b0, 6'h00, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
